// File: rtl/uart_frame_pkg.sv
// Shared constants for the UART status line framer: frame layout, slot indices,
// special characters, FSM state encoding and the frame snapshot record.
package uart_frame_pkg;

    localparam int FRAME_LEN = 18;

    localparam logic [7:0] CH_SP = 8'h20;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;

    // Slots not listed here carry a space
    localparam logic [4:0] SLOT_E1_HI  = 5'd1;
    localparam logic [4:0] SLOT_E1_MID = 5'd2;
    localparam logic [4:0] SLOT_E1_LO  = 5'd3;
    localparam logic [4:0] SLOT_E2_HI  = 5'd5;
    localparam logic [4:0] SLOT_E2_MID = 5'd6;
    localparam logic [4:0] SLOT_E2_LO  = 5'd7;
    localparam logic [4:0] SLOT_T_HI   = 5'd9;
    localparam logic [4:0] SLOT_T_LO   = 5'd10;
    localparam logic [4:0] SLOT_RX     = 5'd12;
    localparam logic [4:0] SLOT_B_HI   = 5'd14;
    localparam logic [4:0] SLOT_B_LO   = 5'd15;
    localparam logic [4:0] SLOT_CR     = 5'd16;
    localparam logic [4:0] SLOT_LF     = 5'd17;
    localparam logic [4:0] SLOT_LAST   = 5'(FRAME_LEN - 1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LOAD      = 3'd1;
    localparam logic [2:0] ST_SEND      = 3'd2;
    localparam logic [2:0] ST_WAIT_ACK  = 3'd3;
    localparam logic [2:0] ST_WAIT_DONE = 3'd4;

    typedef struct packed {
        logic [11:0] enc1;
        logic [11:0] enc2;
        logic [7:0]  temp;
        logic [7:0]  bill;
        logic [7:0]  rx;
    } snap_t;

endpackage

// File: rtl/hex_ascii_nib.sv
// Converts one 4-bit nibble into its uppercase hexadecimal ASCII character.
module hex_ascii_nib (
    input  logic [3:0] nib,
    output logic [7:0] ascii
);

    always_comb begin
        if (nib < 4'hA) begin
            ascii = {4'h0, nib} + 8'h30;
        end else begin
            ascii = {4'h0, nib} + 8'h37;
        end
    end

endmodule

// File: rtl/uart_status_framer.sv
// Periodic ASCII status line generator driving a byte-wide UART transmitter
// through a tx_start / tx_busy handshake; all fields are frozen at frame start.
module uart_status_framer #(
    parameter int AUTO_PERIOD = 100000,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        CLK_10MHZ,
    input  logic        rst_n,
    input  logic        frame_req,
    input  logic [11:0] enc1_pos,
    input  logic [11:0] enc2_pos,
    input  logic [7:0]  temperature,
    input  logic [7:0]  bill_accum,
    input  logic [7:0]  rx_data,
    input  logic        rx_data_ready,
    input  logic        tx_busy,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic        frame_active,
    output logic        frame_done
);

    import uart_frame_pkg::*;

    localparam int CNT_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
    localparam int ACK_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    logic [2:0]       state;
    logic [4:0]       slot;
    logic [CNT_W-1:0] auto_cnt;
    logic [ACK_W-1:0] ack_cnt;
    logic             pending;
    logic             tick;
    logic             take;
    logic [7:0]       rx_latch;
    snap_t            shadow;
    logic [3:0]       nib;
    logic [7:0]       hex_byte;
    logic [7:0]       lit_byte;
    logic             use_hex;

    assign tick = (AUTO_PERIOD != 0) && (auto_cnt == CNT_W'(AUTO_PERIOD - 1));
    assign take = (state == ST_IDLE) && pending && !tx_busy;

    always_ff @(posedge CLK_10MHZ or negedge rst_n) begin
        if (!rst_n) begin
            auto_cnt <= '0;
        end else if (AUTO_PERIOD == 0 || tick) begin
            auto_cnt <= '0;
        end else begin
            auto_cnt <= auto_cnt + 1'b1;
        end
    end

    // A request landing in the same cycle the frame is taken survives for the next frame
    always_ff @(posedge CLK_10MHZ or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= 1'b0;
            rx_latch <= CH_SP;
        end else begin
            pending <= (pending && !take) || tick || frame_req;
            if (rx_data_ready) begin
                rx_latch <= rx_data;
            end
        end
    end

    always_ff @(posedge CLK_10MHZ) begin
        if (state == ST_LOAD) begin
            shadow <= '{enc1: enc1_pos, enc2: enc2_pos, temp: temperature,
                        bill: bill_accum, rx: rx_latch};
        end
    end

    always_ff @(posedge CLK_10MHZ or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            slot       <= '0;
            ack_cnt    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (take) begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    slot  <= '0;
                    state <= ST_SEND;
                end
                ST_SEND: begin
                    ack_cnt <= '0;
                    state   <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    // A transmitter that never acknowledges must not stall the line
                    if (tx_busy || ack_cnt == ACK_W'(ACK_TIMEOUT - 1)) begin
                        state <= ST_WAIT_DONE;
                    end else begin
                        ack_cnt <= ack_cnt + 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!tx_busy) begin
                        if (slot == SLOT_LAST) begin
                            frame_done <= 1'b1;
                            state      <= ST_IDLE;
                        end else begin
                            slot  <= slot + 1'b1;
                            state <= ST_SEND;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        nib      = 4'h0;
        use_hex  = 1'b0;
        lit_byte = CH_SP;
        case (slot)
            SLOT_E1_HI:  begin nib = shadow.enc1[11:8]; use_hex = 1'b1; end
            SLOT_E1_MID: begin nib = shadow.enc1[7:4];  use_hex = 1'b1; end
            SLOT_E1_LO:  begin nib = shadow.enc1[3:0];  use_hex = 1'b1; end
            SLOT_E2_HI:  begin nib = shadow.enc2[11:8]; use_hex = 1'b1; end
            SLOT_E2_MID: begin nib = shadow.enc2[7:4];  use_hex = 1'b1; end
            SLOT_E2_LO:  begin nib = shadow.enc2[3:0];  use_hex = 1'b1; end
            SLOT_T_HI:   begin nib = shadow.temp[7:4];  use_hex = 1'b1; end
            SLOT_T_LO:   begin nib = shadow.temp[3:0];  use_hex = 1'b1; end
            SLOT_B_HI:   begin nib = shadow.bill[7:4];  use_hex = 1'b1; end
            SLOT_B_LO:   begin nib = shadow.bill[3:0];  use_hex = 1'b1; end
            SLOT_RX:     lit_byte = shadow.rx;
            SLOT_CR:     lit_byte = CH_CR;
            SLOT_LF:     lit_byte = CH_LF;
            default:     lit_byte = CH_SP;
        endcase
    end

    hex_ascii_nib u_hex (
        .nib   (nib),
        .ascii (hex_byte)
    );

    // Byte stays on the bus through the whole handshake since slot only moves in WAIT_DONE
    assign tx_start     = (state == ST_SEND);
    assign frame_active = (state != ST_IDLE);
    assign tx_data      = (state == ST_IDLE || state == ST_LOAD) ? 8'h00
                        : (use_hex ? hex_byte : lit_byte);

endmodule

// File: tb/tb_uart_status_framer.sv
// Bench for uart_status_framer: transmitter model, frame-level reference model and
// per-cycle compare process, directed scenarios followed by randomized traffic.
module tb_uart_status_framer;

    localparam int AUTO = 10000;
    localparam int ACKT = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_req = 1'b0;
    logic [11:0] enc1_pos = '0;
    logic [11:0] enc2_pos = '0;
    logic [7:0]  temperature = '0;
    logic [7:0]  bill_accum = '0;
    logic [7:0]  rx_data = '0;
    logic        rx_data_ready = 1'b0;
    logic        tx_busy = 1'b0;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        frame_active;
    logic        frame_done;

    uart_status_framer #(.AUTO_PERIOD(AUTO), .ACK_TIMEOUT(ACKT)) dut (
        .CLK_10MHZ     (clk),
        .rst_n         (rst_n),
        .frame_req     (frame_req),
        .enc1_pos      (enc1_pos),
        .enc2_pos      (enc2_pos),
        .temperature   (temperature),
        .bill_accum    (bill_accum),
        .rx_data       (rx_data),
        .rx_data_ready (rx_data_ready),
        .tx_busy       (tx_busy),
        .tx_start      (tx_start),
        .tx_data       (tx_data),
        .frame_active  (frame_active),
        .frame_done    (frame_done)
    );

    always #50 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input bit ok, input string nm, input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic logic [7:0] hx(input logic [3:0] n);
        return (n < 4'd10) ? ({4'h0, n} + 8'h30) : ({4'h0, n} + 8'h37);
    endfunction

    // transmitter model controls
    bit xmit_en = 1'b1;
    bit xmit_rnd = 1'b0;
    int xmit_len = 5;

    initial begin : xmit
        int dly;
        int left;
        dly = 0;
        left = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n || !xmit_en) begin
                tx_busy = 1'b0;
                dly = 0;
                left = 0;
            end else begin
                if (dly > 0) begin
                    dly--;
                    if (dly == 0) begin
                        tx_busy = 1'b1;
                        left = xmit_rnd ? $urandom_range(1, 40) : xmit_len;
                    end
                end else if (left > 0) begin
                    left--;
                    if (left == 0) tx_busy = 1'b0;
                end
                if (tx_start && dly == 0 && left == 0 && !tx_busy) begin
                    if (!xmit_rnd) dly = 1;
                    else if ($urandom_range(0, 7) != 0) dly = $urandom_range(1, 3);
                end
            end
        end
    end

    // reference model state
    int ncyc = 0, rel_cyc = 0, last_req_cyc = 0, first_start_cyc = 0;
    int frames_started = 0, done_cnt = 0, start_cnt = 0;
    int since = 0, mslot = 0;
    bit pm, pa, pb, preq, prev_rose, in_frame, in_rst;
    logic [7:0]  rx_m = 8'h20;
    logic [11:0] sn_e1, sn_e2;
    logic [7:0]  sn_t, sn_b, sn_rx, held;
    logic [7:0]  exp_b [18];
    logic [7:0]  cap [18];
    int          st [18];

    initial begin : monitor
        bit rose, cm, tick;
        forever begin
            @(negedge clk);
            ncyc++;
            if (!rst_n) begin
                chk(tx_start == 1'b0, "rst_tx_start", int'(tx_start), 0);
                chk(tx_data == 8'h00, "rst_tx_data", int'(tx_data), 0);
                chk(frame_active == 1'b0, "rst_frame_active", int'(frame_active), 0);
                chk(frame_done == 1'b0, "rst_frame_done", int'(frame_done), 0);
                pm = 0; pa = 0; pb = 0; preq = 0; prev_rose = 0; in_frame = 0;
                mslot = 0; since = 0; rx_m = 8'h20; in_rst = 1;
            end else begin
                if (in_rst) begin rel_cyc = ncyc; in_rst = 0; end
                rose = frame_active && !pa;
                chk(rose == (pm && !pa && !pb), "frame_start", int'(rose), int'(pm && !pa && !pb));
                cm = (pm && !rose) || preq;
                tick = (since == AUTO - 1);
                since = tick ? 0 : since + 1;
                if (rose) begin
                    frames_started++;
                    sn_e1 = enc1_pos; sn_e2 = enc2_pos; sn_t = temperature;
                    sn_b = bill_accum; sn_rx = rx_m;
                end
                if (prev_rose) begin
                    chk(tx_start == 1'b1, "first_start", int'(tx_start), 1);
                    in_frame = 1; mslot = 0; first_start_cyc = ncyc;
                    exp_b[0] = 8'h20; exp_b[1] = hx(sn_e1[11:8]); exp_b[2] = hx(sn_e1[7:4]);
                    exp_b[3] = hx(sn_e1[3:0]); exp_b[4] = 8'h20; exp_b[5] = hx(sn_e2[11:8]);
                    exp_b[6] = hx(sn_e2[7:4]); exp_b[7] = hx(sn_e2[3:0]); exp_b[8] = 8'h20;
                    exp_b[9] = hx(sn_t[7:4]); exp_b[10] = hx(sn_t[3:0]); exp_b[11] = 8'h20;
                    exp_b[12] = sn_rx; exp_b[13] = 8'h20; exp_b[14] = hx(sn_b[7:4]);
                    exp_b[15] = hx(sn_b[3:0]); exp_b[16] = 8'h0D; exp_b[17] = 8'h0A;
                end
                if (tx_start) begin
                    start_cnt++;
                    chk(!tx_busy, "start_while_busy", int'(tx_busy), 0);
                    if (in_frame && mslot < 18) begin
                        chk(tx_data == exp_b[mslot], "frame_byte", int'(tx_data), int'(exp_b[mslot]));
                        cap[mslot] = tx_data; st[mslot] = ncyc; held = tx_data; mslot++;
                    end else begin
                        chk(1'b0, "spurious_start", mslot, 18);
                    end
                end else if (in_frame && mslot > 0 && frame_active) begin
                    chk(tx_data == held, "data_hold", int'(tx_data), int'(held));
                end
                chk(frame_done == (pa && !frame_active), "done_pulse", int'(frame_done), int'(pa && !frame_active));
                if (frame_done) begin
                    chk(in_frame && mslot == 18, "done_after_last", mslot, 18);
                    in_frame = 0;
                    done_cnt++;
                end
                if (frame_req) last_req_cyc = ncyc;
                if (rx_data_ready) rx_m = rx_data;
                pm = cm; pa = frame_active; pb = tx_busy; preq = frame_req || tick; prev_rose = rose;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
    endtask

    task automatic pulse_req();
        frame_req = 1'b1;
        step();
        frame_req = 1'b0;
    endtask

    task automatic pulse_rx(input logic [7:0] d);
        rx_data = d;
        rx_data_ready = 1'b1;
        step();
        rx_data_ready = 1'b0;
    endtask

    task automatic wait_done(input int target, input int maxc, input string nm);
        for (int i = 0; i < maxc && done_cnt < target; i++) step();
        chk(done_cnt >= target, nm, done_cnt, target);
    endtask

    task automatic wait_slot(input int s, input int maxc, input string nm);
        for (int i = 0; i < maxc && !(in_frame && mslot >= s); i++) step();
        chk(in_frame && mslot >= s, nm, mslot, s);
    endtask

    initial begin : stim
        logic [8*18-1:0] lit;
        int base_d, base_s, base_c;
        lit = " 1A3 FFF 19   05\r\n";

        // power-on reset, then the auto timer alone starts the first frame
        repeat (3) step();
        chk(tx_start == 1'b0 && frame_active == 1'b0, "por_idle", int'(tx_start), 0);
        rst_n = 1'b1;
        xmit_len = 5;
        for (int i = 0; i < AUTO + 100 && frames_started < 1; i++) step();
        wait_slot(1, 10, "auto_first_start");
        chk(first_start_cyc - rel_cyc == AUTO + 2, "auto_latency", first_start_cyc - rel_cyc, AUTO + 2);
        wait_done(1, 500, "auto_frame_done");

        // literal frame, 434-cycle transmitter, enc1 changed after LOAD
        xmit_len = 434;
        do_reset();
        enc1_pos = 12'h1A3; enc2_pos = 12'hFFF; temperature = 8'h19; bill_accum = 8'h05;
        base_d = done_cnt;
        base_s = frames_started;
        pulse_req();
        wait_slot(1, 10, "req_first_start");
        chk(first_start_cyc - last_req_cyc == 3, "req_latency", first_start_cyc - last_req_cyc, 3);
        enc1_pos = 12'h000;
        wait_done(base_d + 1, 9000, "busy434_done");
        for (int i = 0; i < 18; i++)
            chk(cap[i] == lit[8*(17-i) +: 8], "literal_frame", int'(cap[i]), int'(lit[8*(17-i) +: 8]));
        chk(st[1] - st[0] == 436, "byte_period_busy", st[1] - st[0], 436);
        chk(st[17] - st[0] == 17 * 436, "frame_span_busy", st[17] - st[0], 17 * 436);
        chk(frames_started == base_s + 1, "one_frame", frames_started, base_s + 1);

        // rx latch capture, mid-frame rx strobe, double request while busy
        xmit_len = 10;
        do_reset();
        base_d = done_cnt;
        base_s = frames_started;
        pulse_rx(8'h41);
        pulse_req();
        wait_slot(3, 200, "rx_frame_slot3");
        pulse_rx(8'h42);
        wait_done(base_d + 1, 1000, "rx_frame_done");
        chk(cap[12] == 8'h41, "rx_slot12", int'(cap[12]), 8'h41);
        for (int i = 1; i < 4; i++) chk(cap[i] == 8'h30, "enc1_new_value", int'(cap[i]), 8'h30);
        pulse_req();
        wait_slot(2, 200, "second_frame_slot2");
        pulse_req();
        repeat (5) step();
        pulse_req();
        wait_done(base_d + 2, 1000, "second_frame_done");
        chk(cap[12] == 8'h42, "rx_next_frame", int'(cap[12]), 8'h42);
        wait_done(base_d + 3, 1000, "extra_frame_done");
        repeat (400) step();
        chk(frames_started == base_s + 3, "one_extra_frame", frames_started, base_s + 3);

        // transmitter never acknowledges; reset at slot 7 aborts
        xmit_en = 1'b0;
        do_reset();
        pulse_req();
        wait_slot(2, 200, "timeout_slot2");
        chk(st[1] - st[0] == ACKT + 2, "timeout_period", st[1] - st[0], ACKT + 2);
        for (int i = 0; i < 400 && !(tx_start && mslot == 7); i++) step();
        chk(tx_start && mslot == 7, "reach_slot7", mslot, 7);
        rst_n = 1'b0;
        #1;
        chk(tx_start == 1'b0, "abort_tx_start", int'(tx_start), 0);
        chk(frame_active == 1'b0, "abort_frame_active", int'(frame_active), 0);
        repeat (2) step();
        rst_n = 1'b1;
        base_s = frames_started;
        base_c = start_cnt;
        repeat (300) step();
        chk(frames_started == base_s, "no_restart", frames_started, base_s);
        chk(start_cnt == base_c, "no_start_after_abort", start_cnt, base_c);

        // randomized traffic
        xmit_en = 1'b1;
        xmit_rnd = 1'b1;
        do_reset();
        base_s = frames_started;
        base_d = done_cnt;
        for (int i = 0; i < 6000; i++) begin
            frame_req = ($urandom_range(0, 149) == 0);
            rx_data_ready = ($urandom_range(0, 39) == 0);
            rx_data = 8'($urandom);
            if ($urandom_range(0, 19) == 0) begin
                enc1_pos = 12'($urandom); enc2_pos = 12'($urandom);
                temperature = 8'($urandom); bill_accum = 8'($urandom);
            end
            step();
        end
        frame_req = 1'b0;
        rx_data_ready = 1'b0;
        repeat (1500) step();
        chk(frame_active == 1'b0, "rand_drained", int'(frame_active), 0);
        chk(done_cnt - base_d == frames_started - base_s, "rand_done_count",
            done_cnt - base_d, frames_started - base_s);
        chk(frames_started - base_s > 3, "rand_activity", frames_started - base_s, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_status_framer.md
Name: uart_status_framer

Overview:
- Builds the periodic ASCII status line and drives the async_transmitter byte handshake (tx_start/tx_data/tx_busy) with it.
- Sits between the sensor/peripheral stages (encoder SPI readers, dallas18b20Ctrl, bv_controller, async_receiver) and the UART TX.
- Snapshots all fields at frame start so one line is always coherent.
- Encodes every numeric field as uppercase hex ASCII.

Parameters:
- AUTO_PERIOD, 100000, clock cycles between automatic frame requests (10 ms at 10 MHz); 0 disables the auto timer.
- ACK_TIMEOUT, 16, max cycles to wait for tx_busy to rise after a tx_start pulse.

Ports:
- CLK_10MHZ  in  1  system clock, 10 MHz.
- rst_n  in  1  asynchronous reset, active-low.
- frame_req  in  1  single-cycle request for one frame, in addition to the auto timer.
- enc1_pos  in  12  encoder 1 position.
- enc2_pos  in  12  encoder 2 position.
- temperature  in  8  DS18B20 temperature byte.
- bill_accum  in  8  bill acceptor accumulated count.
- rx_data  in  8  last UART RX byte.
- rx_data_ready  in  1  single-cycle strobe qualifying rx_data.
- tx_busy  in  1  transmitter busy.
- tx_start  out  1  single-cycle byte start to the transmitter.
- tx_data  out  8  byte to transmit; held stable from tx_start until tx_busy falls.
- frame_active  out  1  high while a frame is in progress.
- frame_done  out  1  single-cycle pulse after the last byte completes.

Behaviour:
- Reset: all outputs 0; auto counter 0; pending flag 0; rx_latch = 0x20 (space); FSM in IDLE. Reset mid-frame aborts immediately, and no further tx_start is issued.
- rx_latch: loaded with rx_data on every rx_data_ready, independent of FSM state.
- Auto timer:
  - Counts 0..AUTO_PERIOD-1 and produces a tick on wrap.
  - tick OR frame_req sets pending. Pending is a single bit, so extra requests while already pending are dropped.
- Frame format, 18 bytes, slot 0..17: ' ', E1[11:8], E1[7:4], E1[3:0], ' ', E2[11:8], E2[7:4], E2[3:0], ' ', T[7:4], T[3:0], ' ', rx_latch, ' ', B[7:4], B[3:0], 0x0D, 0x0A.
- Hex encoding: nibble < 0xA gives nibble + 0x30; otherwise nibble + 0x37 ('A'..'F').
- FSM states:
  - IDLE: if pending and tx_busy = 0, go to LOAD and clear pending. A request arriving in the same cycle stays pending for the next frame.
  - LOAD (1 cycle): snapshot enc1_pos, enc2_pos, temperature, bill_accum and rx_latch into shadow registers; slot = 0; frame_active = 1; go to SEND.
  - SEND (1 cycle): tx_data = encoded byte for slot; tx_start = 1; go to WAIT_ACK.
  - WAIT_ACK: on tx_busy = 1, go to WAIT_DONE. If ACK_TIMEOUT cycles elapse with no busy, treat the byte as sent and go to WAIT_DONE; no retry.
  - WAIT_DONE: on tx_busy = 0:
    - slot = 17: frame_done = 1 for one cycle, frame_active = 0, go to IDLE.
    - otherwise: slot + 1, go to SEND.
- Latency: frame_req to first tx_start is 3 cycles when idle (req, IDLE, LOAD, then SEND).
- Inputs changing mid-frame do not affect the current frame.
- Pending set during a frame starts the next frame right after frame_done. Frames are never back-to-back within the same cycle.
- tx_start is never asserted while tx_busy = 1.

Decomposition:
- Package uart_frame_pkg holds:
  - constants FRAME_LEN = 18, CH_SP = 8'h20, CH_CR = 8'h0D, CH_LF = 8'h0A;
  - slot index constants;
  - FSM state encoding.
- One combinational sub-module, hex_ascii_nib: 4-bit to 8-bit ASCII. Instantiate it once on the nibble selected by slot.

Test Plan:
- Reset release, frame_req with enc1 = 0x1A3, enc2 = 0xFFF, temp = 0x19, bill = 0x05, no RX → bytes " 1A3 FFF 19   05\r\n". Slot 12 is space because rx_latch resets to space. frame_done follows the LF.
- rx_data_ready with rx_data = 0x41, then frame_req → slot 12 = 0x41. A second rx strobe with 0x42 mid-frame leaves the current frame unchanged and appears in the next frame.
- Change enc1 to 0x000 after LOAD → current frame still shows "1A3"; the next frame shows "000".
- AUTO_PERIOD = 10000 (bench override) with no frame_req → first tx_start after 10000 + 2 cycles. Two frame_req pulses during a frame → exactly one extra frame.
- Model transmitter busy 434 cycles per byte → a frame lasts about 18×436 cycles. tx_start is never asserted while busy.
- tx_busy tied 0 → each byte advances after ACK_TIMEOUT = 16 cycles. rst_n low at slot 7 → tx_start = 0, frame_active = 0 immediately, with no restart until a new request.
